// File: rtl/csr_reg_if.sv
// CSR block bus: execute-stage read/write, interrupt-controller write, privilege and retire inputs,
// and the registered CSR views back to the interrupt controller.
interface csr_reg_if;
    logic        ex_wr_en_i;
    logic [31:0] ex_wr_addr_i;
    logic [31:0] ex_wr_data_i;
    logic [31:0] ex_rd_addr_i;
    logic [31:0] ex_rd_data_o;
    logic        clint_wr_en_i;
    logic [31:0] clint_wr_addr_i;
    logic [31:0] clint_wr_data_i;
    logic        wr_privilege_en_i;
    logic [1:0]  wr_privilege_ctrl_i;
    logic        instr_retire_i;
    logic [31:0] csr_mtvec_o;
    logic [31:0] csr_mepc_o;
    logic [31:0] csr_mstatus_o;
    logic [1:0]  privilege_o;
    logic        global_int_en_o;

    modport master (
        output ex_wr_en_i, ex_wr_addr_i, ex_wr_data_i, ex_rd_addr_i,
        output clint_wr_en_i, clint_wr_addr_i, clint_wr_data_i,
        output wr_privilege_en_i, wr_privilege_ctrl_i, instr_retire_i,
        input  ex_rd_data_o, csr_mtvec_o, csr_mepc_o, csr_mstatus_o,
        input  privilege_o, global_int_en_o
    );

    modport slave (
        input  ex_wr_en_i, ex_wr_addr_i, ex_wr_data_i, ex_rd_addr_i,
        input  clint_wr_en_i, clint_wr_addr_i, clint_wr_data_i,
        input  wr_privilege_en_i, wr_privilege_ctrl_i, instr_retire_i,
        output ex_rd_data_o, csr_mtvec_o, csr_mepc_o, csr_mstatus_o,
        output privilege_o, global_int_en_o
    );
endinterface

// File: rtl/csr_reg.sv
// Machine-mode CSR file with 64-bit mcycle and write forwarding to the execute stage.
// Define CSR_INSTRET_EN to add the minstret/instret counter.
module csr_reg (
    input logic      sys_clk,
    input logic      sys_reset_n,
    csr_reg_if.slave bus
);
    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;
    localparam logic [11:0] ADDR_CYCLE    = 12'hC00;
    localparam logic [11:0] ADDR_CYCLEH   = 12'hC80;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
    localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;

    localparam logic [31:0] MSTATUS_MASK = 32'h0000_1888;
    localparam logic [31:0] MSTATUS_RST  = 32'h0000_1800;
    localparam logic [31:0] MEPC_MASK    = 32'hFFFF_FFFC;

    function automatic logic is_writable(input logic [11:0] a);
        logic w;
        case (a)
            ADDR_MSTATUS, ADDR_MIE, ADDR_MTVEC, ADDR_MSCRATCH,
            ADDR_MEPC, ADDR_MCAUSE, ADDR_MCYCLE, ADDR_MCYCLEH: w = 1'b1;
`ifdef CSR_INSTRET_EN
            ADDR_MINSTRET, ADDR_MINSTRETH:                    w = 1'b1;
`endif
            default:                                          w = 1'b0;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] wr_mask(input logic [11:0] a);
        logic [31:0] m;
        case (a)
            ADDR_MSTATUS: m = MSTATUS_MASK;
            ADDR_MEPC:    m = MEPC_MASK;
            default:      m = 32'hFFFF_FFFF;
        endcase
        return m;
    endfunction

    logic [31:0] r_mstatus;
    logic [31:0] r_mie;
    logic [31:0] r_mtvec;
    logic [31:0] r_mscratch;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic [63:0] r_mcycle;
    logic [1:0]  r_priv;
    // Cleared by reset so the first edge after release performs no write.
    logic        r_wr_arm;

    logic        w_wr_en;
    logic [11:0] w_wr_addr;
    logic [31:0] w_wr_data;
    logic [11:0] w_rd_addr;
    logic [11:0] w_ex_addr;
    logic [11:0] w_clint_addr;
    logic [31:0] w_rd_stored;
    logic [31:0] w_rd_data;
    logic [63:0] w_mcycle_d;
    logic        w_unused;

    assign w_rd_addr    = bus.ex_rd_addr_i[11:0];
    assign w_ex_addr    = bus.ex_wr_addr_i[11:0];
    assign w_clint_addr = bus.clint_wr_addr_i[11:0];

    // The interrupt controller wins outright; a coincident execute write is dropped.
    always_comb begin
        w_wr_en   = (bus.clint_wr_en_i | bus.ex_wr_en_i) & r_wr_arm;
        w_wr_addr = bus.clint_wr_en_i ? w_clint_addr : w_ex_addr;
        w_wr_data = (bus.clint_wr_en_i ? bus.clint_wr_data_i : bus.ex_wr_data_i)
                    & wr_mask(w_wr_addr);
    end

`ifdef CSR_INSTRET_EN
    logic [63:0] r_minstret;
    logic [63:0] w_minstret_d;

    always_comb begin
        w_minstret_d = r_minstret + {63'd0, bus.instr_retire_i};
        if (w_wr_en && w_wr_addr == ADDR_MINSTRET) begin
            w_minstret_d = {r_minstret[63:32], w_wr_data};
        end else if (w_wr_en && w_wr_addr == ADDR_MINSTRETH) begin
            w_minstret_d = {w_wr_data, r_minstret[31:0]};
        end
    end

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_minstret <= 64'd0;
        end else begin
            r_minstret <= w_minstret_d;
        end
    end

    assign w_unused = ^{bus.ex_wr_addr_i[31:12], bus.clint_wr_addr_i[31:12],
                        bus.ex_rd_addr_i[31:12]};
`else
    assign w_unused = ^{bus.ex_wr_addr_i[31:12], bus.clint_wr_addr_i[31:12],
                        bus.ex_rd_addr_i[31:12], bus.instr_retire_i};
`endif

    always_comb begin
        w_mcycle_d = r_mcycle + 64'd1;
        if (w_wr_en && w_wr_addr == ADDR_MCYCLE) begin
            w_mcycle_d = {r_mcycle[63:32], w_wr_data};
        end else if (w_wr_en && w_wr_addr == ADDR_MCYCLEH) begin
            w_mcycle_d = {w_wr_data, r_mcycle[31:0]};
        end
    end

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_mstatus  <= MSTATUS_RST;
            r_mie      <= 32'd0;
            r_mtvec    <= 32'd0;
            r_mscratch <= 32'd0;
            r_mepc     <= 32'd0;
            r_mcause   <= 32'd0;
            r_mcycle   <= 64'd0;
            r_priv     <= 2'b11;
            r_wr_arm   <= 1'b0;
        end else begin
            r_wr_arm <= 1'b1;
            r_mcycle <= w_mcycle_d;
            if (w_wr_en) begin
                case (w_wr_addr)
                    ADDR_MSTATUS:  r_mstatus  <= w_wr_data;
                    ADDR_MIE:      r_mie      <= w_wr_data;
                    ADDR_MTVEC:    r_mtvec    <= w_wr_data;
                    ADDR_MSCRATCH: r_mscratch <= w_wr_data;
                    ADDR_MEPC:     r_mepc     <= w_wr_data;
                    ADDR_MCAUSE:   r_mcause   <= w_wr_data;
                    default:       ;
                endcase
            end
            if (r_wr_arm && bus.wr_privilege_en_i && bus.wr_privilege_ctrl_i != 2'b10) begin
                r_priv <= bus.wr_privilege_ctrl_i;
            end
        end
    end

    always_comb begin
        case (w_rd_addr)
            ADDR_MSTATUS:               w_rd_stored = r_mstatus;
            ADDR_MIE:                   w_rd_stored = r_mie;
            ADDR_MTVEC:                 w_rd_stored = r_mtvec;
            ADDR_MSCRATCH:              w_rd_stored = r_mscratch;
            ADDR_MEPC:                  w_rd_stored = r_mepc;
            ADDR_MCAUSE:                w_rd_stored = r_mcause;
            ADDR_MCYCLE, ADDR_CYCLE:    w_rd_stored = r_mcycle[31:0];
            ADDR_MCYCLEH, ADDR_CYCLEH:  w_rd_stored = r_mcycle[63:32];
`ifdef CSR_INSTRET_EN
            ADDR_MINSTRET, ADDR_INSTRET:   w_rd_stored = r_minstret[31:0];
            ADDR_MINSTRETH, ADDR_INSTRETH: w_rd_stored = r_minstret[63:32];
`endif
            default:                    w_rd_stored = 32'd0;
        endcase
    end

    // Forward pending writes so a same-cycle read sees the value about to be stored.
    always_comb begin
        w_rd_data = w_rd_stored;
        if (bus.clint_wr_en_i && w_clint_addr == w_rd_addr && is_writable(w_rd_addr)) begin
            w_rd_data = bus.clint_wr_data_i & wr_mask(w_rd_addr);
        end else if (bus.ex_wr_en_i && w_ex_addr == w_rd_addr && is_writable(w_rd_addr)) begin
            w_rd_data = bus.ex_wr_data_i & wr_mask(w_rd_addr);
        end
    end

    assign bus.ex_rd_data_o    = w_rd_data;
    assign bus.csr_mtvec_o     = r_mtvec;
    assign bus.csr_mepc_o      = r_mepc;
    assign bus.csr_mstatus_o   = r_mstatus;
    assign bus.privilege_o     = r_priv;
    assign bus.global_int_en_o = r_mstatus[3];
endmodule

// File: tb/tb_csr_reg.sv
// Directed bench for csr_reg: reset values, forwarding, write priority, masks, counters,
// privilege updates and asynchronous reset. Honors CSR_INSTRET_EN for the retire counter.
module tb_csr_reg;
    logic sys_clk     = 1'b0;
    logic sys_reset_n = 1'b1;
    int   n_pass      = 0;
    int   n_fail      = 0;
    int   n_total     = 0;

    always #5 sys_clk = ~sys_clk;

    csr_reg_if u_if ();

    csr_reg u_dut (
        .sys_clk    (sys_clk),
        .sys_reset_n(sys_reset_n),
        .bus        (u_if)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic clear();
        u_if.ex_wr_en_i        = 1'b0;
        u_if.clint_wr_en_i     = 1'b0;
        u_if.wr_privilege_en_i = 1'b0;
        u_if.instr_retire_i    = 1'b0;
    endtask

    task automatic ex_wr(input logic [31:0] a, input logic [31:0] d);
        u_if.ex_wr_en_i   = 1'b1;
        u_if.ex_wr_addr_i = a;
        u_if.ex_wr_data_i = d;
    endtask

    task automatic clint_wr(input logic [31:0] a, input logic [31:0] d);
        u_if.clint_wr_en_i   = 1'b1;
        u_if.clint_wr_addr_i = a;
        u_if.clint_wr_data_i = d;
    endtask

    task automatic rd(input logic [31:0] a);
        u_if.ex_rd_addr_i = a;
        #1;
    endtask

    initial begin
        #5000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        logic [31:0] instret_exp;
        clear();
        u_if.ex_wr_addr_i        = 32'd0;
        u_if.ex_wr_data_i        = 32'd0;
        u_if.clint_wr_addr_i     = 32'd0;
        u_if.clint_wr_data_i     = 32'd0;
        u_if.wr_privilege_ctrl_i = 2'b00;
        u_if.ex_rd_addr_i        = 32'h300;
        #1 sys_reset_n = 1'b0;
        ex_wr(32'h305, 32'hDEAD_BEEF);
        #11;
        check("rst_mstatus_rd", u_if.ex_rd_data_o, 32'h0000_1800);
        check("rst_priv", {30'd0, u_if.privilege_o}, 32'd3);
        check("rst_gie", {31'd0, u_if.global_int_en_o}, 32'd0);
        check("rst_mtvec_o", u_if.csr_mtvec_o, 32'd0);

        // Release between edges while a write is held; first edge must drop it.
        #10 sys_reset_n = 1'b1;
        tick();
        clear();
        rd(32'hB00);
        check("first_edge_no_write", u_if.csr_mtvec_o, 32'd0);
        check("mcycle_after_1", u_if.ex_rd_data_o, 32'd1);
        rd(32'hC00);
        check("cycle_alias_1", u_if.ex_rd_data_o, 32'd1);
        tick();
        rd(32'hB00);
        check("mcycle_after_2", u_if.ex_rd_data_o, 32'd2);

        ex_wr(32'h305, 32'h8000_0100);
        rd(32'h305);
        check("mtvec_fwd", u_if.ex_rd_data_o, 32'h8000_0100);
        check("mtvec_o_before_edge", u_if.csr_mtvec_o, 32'd0);
        tick();
        clear();
        rd(32'hABCD_0305);
        check("mtvec_o_after_edge", u_if.csr_mtvec_o, 32'h8000_0100);
        check("mtvec_rd_hi_bits_ignored", u_if.ex_rd_data_o, 32'h8000_0100);

        clint_wr(32'h341, 32'h0000_0206);
        ex_wr(32'h340, 32'h0000_1234);
        tick();
        clear();
        rd(32'h340);
        check("clint_mepc_masked", u_if.csr_mepc_o, 32'h0000_0204);
        check("ex_dropped_mscratch", u_if.ex_rd_data_o, 32'd0);

        clint_wr(32'h342, 32'h0000_000A);
        ex_wr(32'h342, 32'h0000_000B);
        rd(32'h342);
        check("same_addr_fwd_clint", u_if.ex_rd_data_o, 32'h0000_000A);
        tick();
        clear();
        rd(32'h342);
        check("same_addr_store_clint", u_if.ex_rd_data_o, 32'h0000_000A);

        ex_wr(32'h341, 32'hFFFF_FFFF);
        rd(32'h341);
        check("mepc_fwd_mask", u_if.ex_rd_data_o, 32'hFFFF_FFFC);
        tick();
        clear();
        ex_wr(32'h304, 32'hFFFF_FFFF);
        tick();
        clear();
        rd(32'h304);
        check("mie_full", u_if.ex_rd_data_o, 32'hFFFF_FFFF);

        ex_wr(32'hB80, 32'd0);
        tick();
        ex_wr(32'hB00, 32'hFFFF_FFFF);
        tick();
        clear();
        rd(32'hB00);
        check("mcycle_preload_lo", u_if.ex_rd_data_o, 32'hFFFF_FFFF);
        rd(32'hB80);
        check("mcycle_preload_hi", u_if.ex_rd_data_o, 32'd0);
        tick();
        rd(32'hB00);
        check("mcycle_carry_lo", u_if.ex_rd_data_o, 32'd0);
        rd(32'hB80);
        check("mcycle_carry_hi", u_if.ex_rd_data_o, 32'd1);
        rd(32'hC80);
        check("cycleh_alias", u_if.ex_rd_data_o, 32'd1);

        ex_wr(32'hC80, 32'h0000_0055);
        rd(32'hC80);
        check("cycleh_ro_no_fwd", u_if.ex_rd_data_o, 32'd1);
        tick();
        clear();
        rd(32'hB80);
        check("cycleh_ro_ignored", u_if.ex_rd_data_o, 32'd1);

        ex_wr(32'h123, 32'hFFFF_FFFF);
        rd(32'h123);
        check("unimpl_no_fwd", u_if.ex_rd_data_o, 32'd0);
        tick();
        clear();
        rd(32'h123);
        check("unimpl_rd_zero", u_if.ex_rd_data_o, 32'd0);

        ex_wr(32'h300, 32'hFFFF_FFFF);
        rd(32'h300);
        check("mstatus_fwd_mask", u_if.ex_rd_data_o, 32'h0000_1888);
        check("gie_before_edge", {31'd0, u_if.global_int_en_o}, 32'd0);
        tick();
        clear();
        check("mstatus_o_mask", u_if.csr_mstatus_o, 32'h0000_1888);
        check("gie_set", {31'd0, u_if.global_int_en_o}, 32'd1);

        u_if.wr_privilege_en_i   = 1'b1;
        u_if.wr_privilege_ctrl_i = 2'b10;
        tick();
        clear();
        check("priv_reserved_ignored", {30'd0, u_if.privilege_o}, 32'd3);
        u_if.wr_privilege_en_i   = 1'b1;
        u_if.wr_privilege_ctrl_i = 2'b00;
        tick();
        clear();
        check("priv_user", {30'd0, u_if.privilege_o}, 32'd0);
        u_if.wr_privilege_ctrl_i = 2'b01;
        tick();
        check("priv_no_en_hold", {30'd0, u_if.privilege_o}, 32'd0);
        u_if.wr_privilege_en_i = 1'b1;
        tick();
        clear();
        check("priv_super", {30'd0, u_if.privilege_o}, 32'd1);

`ifdef CSR_INSTRET_EN
        instret_exp = 32'd5;
`else
        instret_exp = 32'd0;
`endif
        rd(32'hB02);
        check("instret_start", u_if.ex_rd_data_o, 32'd0);
        for (int i = 0; i < 5; i++) begin
            u_if.instr_retire_i = 1'b1;
            tick();
            u_if.instr_retire_i = 1'b0;
            tick();
        end
        rd(32'hB02);
        check("minstret_count", u_if.ex_rd_data_o, instret_exp);
        rd(32'hC02);
        check("instret_alias", u_if.ex_rd_data_o, instret_exp);

        // Asynchronous reset asserted between edges.
        rd(32'h300);
        #2 sys_reset_n = 1'b0;
        #1;
        check("async_rst_mstatus", u_if.ex_rd_data_o, 32'h0000_1800);
        check("async_rst_gie", {31'd0, u_if.global_int_en_o}, 32'd0);
        check("async_rst_priv", {30'd0, u_if.privilege_o}, 32'd3);
        check("async_rst_mepc_o", u_if.csr_mepc_o, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/csr_reg.md
CSR_REG -- requirements
Module: csr_reg

Interface
REQ-001 SHALL have port sys_clk, input, 1: sole clock, rising edge.
REQ-002 SHALL have port sys_reset_n, input, 1: reset, asynchronous assert, active-low.
REQ-003 SHALL have ports ex_wr_en_i (1), ex_wr_addr_i (32) and ex_wr_data_i (32), all inputs: CSR write from the execute stage (CSRRW/S/C result).
REQ-004 SHALL have ports ex_rd_addr_i (32, input) and ex_rd_data_o (32, output): combinational CSR read for the execute stage.
REQ-005 SHALL have ports clint_wr_en_i (1), clint_wr_addr_i (32) and clint_wr_data_i (32), all inputs: trap-entry and mret writes from the interrupt controller.
REQ-006 SHALL have ports wr_privilege_en_i (1, input) and wr_privilege_ctrl_i (2, input): privilege update request.
REQ-007 SHALL have port instr_retire_i, input, 1: one instruction retired this cycle.
REQ-008 SHALL have outputs csr_mtvec_o, csr_mepc_o and csr_mstatus_o, each 32: registered CSR views to the interrupt controller.
REQ-009 SHALL have outputs privilege_o (2): current privilege, and global_int_en_o (1): equals mstatus[3].

Function
REQ-010 SHALL implement mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mcycle/mcycleh 0xB00/0xB80, and cycle/cycleh 0xC00/0xC80 (read-only aliases of mcycle).
REQ-011 Address compare SHALL use bits [11:0]; bits [31:12] are ignored.
REQ-012 Writes SHALL take effect on the rising edge after the write enable is sampled high; latency is 1 cycle.
REQ-013 When clint_wr_en_i and ex_wr_en_i are both high in the same cycle, the clint write SHALL win and the ex write SHALL be dropped, even if the addresses differ.
REQ-014 mstatus SHALL store only MIE[3], MPIE[7] and MPP[12:11]; all other bits SHALL read 0.
REQ-015 mepc writes SHALL force bits [1:0] to 0.
REQ-016 mtvec, mie, mscratch and mcause SHALL store all 32 bits.
REQ-017 Writes to 0xC00/0xC80 or to an unimplemented address SHALL be ignored; reads of an unimplemented address SHALL return 0.
REQ-018 ex_rd_data_o SHALL forward the pending clint write data when clint_wr_en_i is high and the address matches. Otherwise it SHALL forward ex_wr_data_i when ex_wr_en_i is high and the address matches. Otherwise it SHALL return the stored value. mstatus and mepc masks SHALL apply to forwarded data.
REQ-019 mcycle SHALL be a 64-bit counter that increments every cycle and wraps from 0xFFFF_FFFF_FFFF_FFFF to 0.
REQ-020 A write to mcycle SHALL load the low word and hold the high word; a write to mcycleh SHALL load the high word and hold the low word. No increment occurs in that cycle.
REQ-021 privilege_o SHALL load wr_privilege_ctrl_i on the edge where wr_privilege_en_i is high.
REQ-022 A wr_privilege_ctrl_i value of 2'b10 (reserved) SHALL be ignored.
REQ-023 csr_mtvec_o, csr_mepc_o and csr_mstatus_o SHALL reflect the stored registers with no forwarding.

Reset
REQ-024 On sys_reset_n low, asynchronously: mstatus = 0x0000_1800 (MPP = machine, MIE = 0), privilege_o = 2'b11, and all other CSRs and counters = 0.
REQ-025 Reset SHALL abort any in-flight write, and the first edge after release SHALL perform no write.
REQ-026 global_int_en_o SHALL be 0 during reset.

Configuration
REQ-027 With CSR_INSTRET_EN defined, the block SHALL implement minstret/minstreth 0xB02/0xB82 and instret/instreth 0xC02/0xC82 (read-only). This counter is 64-bit, wrapping, increments when instr_retire_i is high, and follows the REQ-020 write rules.
REQ-028 Without CSR_INSTRET_EN, those addresses SHALL be unimplemented per REQ-017 and instr_retire_i SHALL be ignored.

Verification
REQ-029 Reset release then read 0x300 -> 0x0000_1800; privilege_o = 2'b11; read 0xB00 increments by 1 per cycle.
REQ-030 ex write 0x305 = 0x8000_0100 -> csr_mtvec_o = 0x8000_0100 after 1 edge; same-cycle read of 0x305 returns 0x8000_0100.
REQ-031 Same cycle: clint write 0x341 = 0x0000_0206 and ex write 0x340 = 0x1234 -> mepc = 0x0000_0204; mscratch unchanged at 0.
REQ-032 Preload mcycle = 0xFFFF_FFFF with mcycleh = 0 -> next cycle reads 0xB00 = 0 and 0xB80 = 1.
REQ-033 ex write 0x300 = 0xFFFF_FFFF -> reads 0x0000_1888 and global_int_en_o = 1; wr_privilege_ctrl_i = 2'b10 with enable -> privilege_o unchanged.
REQ-034 With CSR_INSTRET_EN, pulse instr_retire_i 5 times -> 0xB02 reads 5. Without the macro -> 0xB02 reads 0.
